hi_lo_multiply_divide_unit: RTL and testbench
=============================================

// Module: hi_lo_multiply_divide_unit
// PURPOSE
//  Execute-stage consumer of the decode/execute pipeline outputs for HI/LO instructions.
//  Runs MULT/MULTU/DIV/DIVU iteratively and owns the architectural HI and LO registers.
//  Raises busy so the hazard logic stalls/clears the pipeline until the result is written.
//  MTHI/MTLO write in one cycle; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  DATA_WIDTH  32  operand, HI and LO width
//  ITERATIONS  32  shift/add or shift/subtract steps per op; must equal DATA_WIDTH
// PORTS
//  clk                  in   1   rising-edge clock
//  clear_n              in   1   asynchronous, active-low reset
//  start_execute        in   1   hi_lo_register_write_execute qualified by a valid execute slot
//  ALU_function_execute in   6   0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
//  operand_a            in   32  forwarded Rs value: multiplicand, dividend, or MTHI/MTLO data
//  operand_b            in   32  forwarded Rt value: multiplier or divisor
//  cancel               in   1   flush: abandon the op in flight, HI/LO unchanged
//  busy                 out  1   op in flight; decode and execute must stall
//  done                 out  1   one-cycle pulse in the cycle after HI/LO take a mult/div result
//  hi                   out  32  HI register
//  lo                   out  32  LO register
// BEHAVIOUR
//  Reset (clear_n=0, async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//  States: IDLE, RUN, FINISH. busy=1 exactly when state is RUN or FINISH.
//  Accept: at a clk edge with state=IDLE and start_execute=1.
//  Accept of 0x18-0x1B:
//   - latch operand magnitudes: abs() for MULT/DIV, raw for MULTU/DIVU
//   - latch the result-sign flags
//   - counter=0, state->RUN
//  Accept of 0x11/0x13: hi (resp. lo) <= operand_a at that edge; state stays IDLE; no done.
//  Accept of any other function code: ignored.
//  start_execute while busy=1: ignored; the pipeline guarantees it is held by the stall.
//  RUN: one iteration per cycle, counter++. After ITERATIONS cycles, state->FINISH.
//   - Multiply: 64-bit shift-add.
//   - Divide: restoring shift-subtract; quotient in LO, remainder in HI.
//  FINISH: apply sign correction.
//   - Signed multiply: negate the 64-bit product if operand signs differ.
//   - Signed divide: quotient negative if signs differ; remainder takes the dividend sign.
//   - At the edge ending FINISH: {hi,lo} written, state->IDLE.
//   - done=1 in the following cycle only.
//  Latency, accept at edge T:
//   - busy high cycles T+1..T+33
//   - hi/lo valid and done=1 in cycle T+34
//   - a new op can be accepted at the edge ending T+34
//  Divide by zero (either signedness): hi=operand_a, lo=32'hFFFFFFFF; same latency; no exception.
//  Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  cancel=1 in RUN/FINISH: at the next edge state->IDLE, no HI/LO write, no done.
//  cancel=1 in IDLE: ignored. cancel beats a simultaneous accept, which is dropped.
//  cancel in the same edge FINISH would commit: cancel wins, no write.
//  MFHI/MFLO hazard: hi/lo show the new value from cycle T+34. Reading earlier is prevented by busy.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles, then hi=0xFFFFFFFE lo=0x00000001, done pulses once.
//  2. MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB.
//     DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  3. DIVU a=100 b=0 -> hi=0x00000064 lo=0xFFFFFFFF after normal latency.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4. MTHI a=0x1234 then MTLO a=0x5678 on back-to-back edges -> hi=0x1234, lo=0x5678.
//     busy never asserts.
//  5. DIVU 50/5 started; second DIVU with different operands asserted during busy -> ignored.
//     Result lo=10 hi=0; exactly one done.
//  6. MULTU started, cancel at cycle T+10 -> busy drops at T+11, hi/lo unchanged, no done.
//     Repeat with clear_n low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/hi_lo_multiply_divide_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO registers; MTHI/MTLO write in one cycle.
// Latency: accept at edge T, busy for cycles T+1..T+33, HI/LO valid and done pulsed in cycle T+34.
// Backpressure: busy stalls the pipeline; start while busy is ignored; cancel abandons the op with HI/LO unchanged.
module hi_lo_multiply_divide_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = 32
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start_execute,
    input  logic [5:0]            ALU_function_execute,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      counter;
    logic [DATA_WIDTH-1:0] work_hi;
    logic [DATA_WIDTH-1:0] work_lo;
    logic [DATA_WIDTH-1:0] operand_reg;
    logic                  is_div;
    logic                  neg_main;
    logic                  neg_rem;
    logic                  div_zero;

    logic accept_md;
    logic accept_mthi;
    logic accept_mtlo;
    logic commit;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept_md   = 1'b0;
        accept_mthi = 1'b0;
        accept_mtlo = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                // A simultaneous flush drops the accept entirely.
                if (start_execute && !cancel) begin
                    case (ALU_function_execute)
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            accept_md = 1'b1;
                            state_nxt = RUN;
                        end
                        FN_MTHI: accept_mthi = 1'b1;
                        FN_MTLO: accept_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (counter == LAST_ITER) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                commit    = !cancel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FINISH);

    // ---------------- operand conditioning ----------------
    logic                  signed_op;
    logic                  mult_op;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;

    always_comb begin
        signed_op = (ALU_function_execute == FN_MULT) || (ALU_function_execute == FN_DIV);
        mult_op   = (ALU_function_execute == FN_MULT) || (ALU_function_execute == FN_MULTU);
        a_mag     = (signed_op && operand_a[DATA_WIDTH-1]) ? ('0 - operand_a) : operand_a;
        b_mag     = (signed_op && operand_b[DATA_WIDTH-1]) ? ('0 - operand_b) : operand_b;
    end

    // ---------------- iteration step ----------------
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shifted;
    logic [DATA_WIDTH-1:0] div_diff;
    logic                  div_ge;

    always_comb begin
        mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_reg} : '0);
        div_shifted = {work_hi, work_lo[DATA_WIDTH-1]};
        div_ge      = div_shifted >= {1'b0, operand_reg};
        // When div_ge holds the true difference is below the divisor, so the low bits suffice.
        div_diff    = div_shifted[DATA_WIDTH-1:0] - operand_reg;
    end

    // ---------------- sign correction ----------------
    logic [2*DATA_WIDTH-1:0] product;
    logic [DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]   remainder;
    logic [DATA_WIDTH-1:0]   result_hi;
    logic [DATA_WIDTH-1:0]   result_lo;

    always_comb begin
        product   = {work_hi, work_lo};
        quotient  = work_lo;
        remainder = work_hi;
        if (neg_main) begin
            product  = '0 - product;
            quotient = '0 - quotient;
        end
        if (neg_rem) begin
            remainder = '0 - remainder;
        end
        if (is_div) begin
            // Divide by zero leaves |a| in the remainder; re-signing it restores operand_a.
            result_hi = remainder;
            result_lo = div_zero ? '1 : quotient;
        end else begin
            result_hi = product[2*DATA_WIDTH-1:DATA_WIDTH];
            result_lo = product[DATA_WIDTH-1:0];
        end
    end

    // ---------------- datapath and architectural registers ----------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            counter     <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            operand_reg <= '0;
            is_div      <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            div_zero    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
        end else begin
            done <= commit;
            if (accept_md) begin
                counter     <= '0;
                work_hi     <= '0;
                work_lo     <= mult_op ? b_mag : a_mag;
                operand_reg <= mult_op ? a_mag : b_mag;
                is_div      <= !mult_op;
                neg_main    <= signed_op && (operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1]);
                neg_rem     <= signed_op && !mult_op && operand_a[DATA_WIDTH-1];
                div_zero    <= (operand_b == '0);
            end else if (state == RUN) begin
                counter <= counter + 1'b1;
                if (is_div) begin
                    work_hi <= div_ge ? div_diff : div_shifted[DATA_WIDTH-1:0];
                    work_lo <= {work_lo[DATA_WIDTH-2:0], div_ge};
                end else begin
                    work_hi <= mul_sum[DATA_WIDTH:1];
                    work_lo <= {mul_sum[0], work_lo[DATA_WIDTH-1:1]};
                end
            end
            if (accept_mthi) begin
                hi <= operand_a;
            end
            if (accept_mtlo) begin
                lo <= operand_a;
            end
            if (commit) begin
                hi <= result_hi;
                lo <= result_lo;
            end
        end
    end

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and random ops vs. an arithmetic model.
module tb_hi_lo_multiply_divide_unit;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        start_execute;
    logic [5:0]  ALU_function_execute;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
    localparam logic [5:0] MTHI = 6'h11, MTLO = 6'h13;

    always #5 clk = ~clk;

    hi_lo_multiply_divide_unit dut (
        .clk                  (clk),
        .clear_n              (clear_n),
        .start_execute        (start_execute),
        .ALU_function_execute (ALU_function_execute),
        .operand_a            (operand_a),
        .operand_b            (operand_b),
        .cancel               (cancel),
        .busy                 (busy),
        .done                 (done),
        .hi                   (hi),
        .lo                   (lo)
    );

    typedef struct {
        string       name;
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from plain integer arithmetic.
    function automatic void model(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] m_hi, output logic [31:0] m_lo);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = int'(a);
        sb = int'(b);
        m_hi = 32'h0;
        m_lo = 32'h0;
        case (func)
            MULT: begin
                sp = longint'(sa) * longint'(sb);
                {m_hi, m_lo} = sp;
            end
            MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                {m_hi, m_lo} = up;
            end
            DIV: begin
                if (sb == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && sb == -1) begin
                    m_hi = 32'h0;
                    m_lo = 32'h8000_0000;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            DIVU: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_execute        = 1'b1;
        ALU_function_execute = func;
        operand_a            = a;
        operand_b            = b;
        @(negedge clk);
        start_execute = 1'b0;
    endtask

    // Issues one mult/div op and checks busy length, done pulse and result.
    task automatic run_op(input string name, input logic [5:0] func, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        issue(func, a, b);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 64'(cnt), 64'd33);
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check({name, " done_one_cycle"}, 64'(done), 64'd0);
    endtask

    task automatic mt(input logic [5:0] func, input logic [31:0] a);
        issue(func, a, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dones;
        logic [31:0] rh, rl, ra, rb;
        logic [5:0]  rf;
        logic [5:0]  md_codes[4];

        vecs[0] = '{"multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{"mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{"div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu_zero", DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4] = '{"div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{"div_zero_s",DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
        vecs[6] = '{"mult_min",  MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{"divu_big",  DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
        vecs[8] = '{"div_negb",  DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{"mult_zero", MULT,  32'h0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        md_codes = '{MULT, MULTU, DIV, DIVU};

        clear_n              = 1'b0;
        start_execute        = 1'b0;
        ALU_function_execute = 6'h0;
        operand_a            = 32'h0;
        operand_b            = 32'h0;
        cancel               = 1'b0;

        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        clear_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // MTHI then MTLO on back-to-back edges; busy must stay low.
        @(negedge clk);
        start_execute = 1'b1; ALU_function_execute = MTHI; operand_a = 32'h1234;
        @(negedge clk);
        check("mthi busy", 64'(busy), 64'd0);
        ALU_function_execute = MTLO; operand_a = 32'h5678;
        @(negedge clk);
        start_execute = 1'b0;
        check("mtlo busy", 64'(busy), 64'd0);
        check("mt hi", 64'(hi), 64'h1234);
        check("mt lo", 64'(lo), 64'h5678);
        check("mt done", 64'(done), 64'd0);

        // Unknown function code is ignored.
        issue(6'h20, 32'hDEAD_BEEF, 32'h1);
        check("bad_fn busy", 64'(busy), 64'd0);
        check("bad_fn hi", 64'(hi), 64'h1234);

        // Second start during busy is ignored.
        issue(DIVU, 32'd50, 32'd5);
        repeat (3) @(negedge clk);
        start_execute = 1'b1; ALU_function_execute = DIVU; operand_a = 32'd99; operand_b = 32'd7;
        repeat (5) @(negedge clk);
        start_execute = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("held_start dones", 64'(dones), 64'd1);
        check("held_start lo", 64'(lo), 64'd10);
        check("held_start hi", 64'(hi), 64'd0);
        check("held_start busy", 64'(busy), 64'd0);

        // Cancel at cycle T+10 during RUN.
        mt(MTHI, 32'hAAAA_0001);
        mt(MTLO, 32'h5555_0002);
        issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        check("cancel_run busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_run busy_after", 64'(busy), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("cancel_run dones", 64'(dones), 64'd0);
        check("cancel_run hi", 64'(hi), 64'hAAAA_0001);
        check("cancel_run lo", 64'(lo), 64'h5555_0002);

        // Cancel in the FINISH cycle suppresses the commit.
        issue(MULTU, 32'd3, 32'd5);
        repeat (32) @(negedge clk);
        check("cancel_fin busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_fin busy_after", 64'(busy), 64'd0);
        check("cancel_fin done", 64'(done), 64'd0);
        @(negedge clk);
        check("cancel_fin done2", 64'(done), 64'd0);
        check("cancel_fin lo", 64'(lo), 64'h5555_0002);

        // Cancel in IDLE beats a simultaneous accept.
        @(negedge clk);
        start_execute = 1'b1; ALU_function_execute = MTHI; operand_a = 32'hDEAD_0000; cancel = 1'b1;
        @(negedge clk);
        ALU_function_execute = MULT; operand_a = 32'd2; operand_b = 32'd3;
        @(negedge clk);
        start_execute = 1'b0; cancel = 1'b0;
        check("cancel_idle hi", 64'(hi), 64'hAAAA_0001);
        check("cancel_idle busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-RUN clears everything immediately.
        issue(MULTU, 32'h7, 32'h9);
        repeat (5) @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        check("rst_run busy", 64'(busy), 64'd0);
        check("rst_run hi", 64'(hi), 64'd0);
        check("rst_run lo", 64'(lo), 64'd0);
        check("rst_run done", 64'(done), 64'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // Random ops against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            rf = md_codes[$urandom_range(0, 3)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            model(rf, ra, rb, rh, rl);
            run_op($sformatf("rand%0d_fn%h", k, rf), rf, ra, rb, rh, rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
